ram_port_master: RTL and testbench
==================================

# ram_port_master

Command-driven initiator for the single-port RAM with false synchronous read. It accepts single-word write and burst read commands over a valid/ready handshake. It drives the RAM port (`we`, `a`, `di`), samples `do` at the correct cycle, and returns read data on a stream interface with backpressure. It replaces ad-hoc bench sequencing, so control logic can own the RAM directly.

## Interface
- `AW`, 5, address width; RAM depth is 2^AW words.
- `DW`, 4, data width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command (high only in IDLE).
- `cmd_we`  in  1  1 = write, 0 = burst read.
- `cmd_addr`  in  AW  write address, or burst start address.
- `cmd_len`  in  AW  read burst length minus 1 (0 means 1 word, max 2^AW words); ignored on writes.
- `cmd_wdata`  in  DW  write data.
- `cmd_err`  out  1  one-cycle pulse when a command is rejected (macro-dependent; otherwise tied 0).
- `ram_we`  out  1  RAM write enable.
- `ram_a`  out  AW  RAM address.
- `ram_di`  out  DW  RAM write data.
- `ram_do`  in  DW  RAM read data: `mem[address registered at previous edge]`.
- `rd_valid`  out  1  read beat valid.
- `rd_ready`  in  1  consumer accepts beat.
- `rd_data`  out  DW  read beat data (equals `ram_do` while `rd_valid`).
- `rd_last`  out  1  final beat of the burst.

## Operation
- Reset values:
  - FSM goes to IDLE.
  - `cmd_ready` is 1 once in IDLE after reset release; it is 0 while `rst_n` is low.
  - `ram_we` = 0, `ram_a` = 0, `ram_di` = 0.
  - `rd_valid` = 0, `rd_last` = 0, `cmd_err` = 0.
  - Internal address and beat counters = 0.
- States:
  - IDLE:
    - `cmd_ready` = 1.
    - On `cmd_valid & cmd_ready`, latch addr/data/len.
    - Go to WRITE if `cmd_we`, else RADDR.
  - WRITE (1 cycle):
    - `ram_we` = 1, `ram_a` = latched addr, `ram_di` = latched data.
    - Then go to IDLE.
  - RADDR (1 cycle):
    - `ram_we` = 0, `ram_a` = start addr.
    - The RAM registers the address at the end of this cycle.
    - Then go to RDATA.
  - RDATA:
    - `rd_valid` = 1, `rd_data` = `ram_do`, `rd_last` = (beat count == latched len).
    - If `rd_ready` = 0: `ram_a` holds the current beat address, so `ram_do` stays stable.
    - If `rd_ready` = 1 and not last: `ram_a` = current + 1 (mod 2^AW), then advance the beat count.
    - If `rd_ready` = 1 and last: go to IDLE.
- `ram_a` is combinational from state, current address and `rd_ready` only in RDATA. All other outputs are registered or pure state decodes.
- Address arithmetic is AW-bit unsigned; incrementing past 2^AW-1 wraps to 0 (unless the macro below is enabled).
- Commands are never accepted outside IDLE. `cmd_valid` held high during a burst simply waits.
- `ram_we` is never asserted outside WRITE. A read never overlaps a write.
- Reset asserted mid-burst or mid-write:
  - All outputs go immediately to their reset values.
  - `ram_we` drops asynchronously.
  - The burst is abandoned; no further beats are produced.

## Timing
- Write:
  - Handshake at edge N.
  - `ram_we` is high during cycle N+1; the RAM stores the word at edge N+2.
  - `cmd_ready` returns high in cycle N+2.
- Read:
  - Handshake at edge N.
  - RADDR occupies cycle N+1.
  - First `rd_valid` is in cycle N+2.
  - With `rd_ready` held at 1, one beat per cycle; an L-word burst ends with the beat in cycle N+1+L.
  - IDLE is in cycle N+2+L.
- Back-to-back commands: the minimum command spacing is 2 cycles for a write and L+2 cycles for a read.
- A write followed immediately by a read of the same address returns the new data (the write completes before RADDR).

## Configuration
- `RAM_MASTER_WRAP_ERR_EN`:
  - Defined: a read whose `cmd_addr + cmd_len` exceeds 2^AW-1 is accepted but not executed.
    - `cmd_err` pulses for one cycle, the cycle after the handshake.
    - The FSM stays in IDLE.
    - No RAM access occurs and no `rd_valid` is produced.
  - Undefined:
    - Bursts wrap modulo 2^AW.
    - `cmd_err` is constant 0.

## Test plan
- Reset mid-burst:
  - Stimulus: start a 4-word read, then pull `rst_n` low in the 2nd RDATA cycle.
  - Response: `rd_valid` and `ram_we` go to 0 immediately.
  - After release, `cmd_ready` = 1 and no stale beats appear.
- Write then single read:
  - Stimulus: write addr 3 = 4'b1001, write addr 7 = 4'b1100, then read addr 3 with len 0.
  - Response: one beat of 1001 with `rd_last` = 1, exactly 2 cycles after the handshake.
- Burst read:
  - Stimulus: preload addr 6..9 with 1, 2, 3, 4; read addr 6 with len 3 and `rd_ready` held at 1.
  - Response: beats 1, 2, 3, 4 on consecutive cycles; `rd_last` only on the 4.
- Backpressure:
  - Stimulus: same burst with `rd_ready` low for 3 cycles on beat 2.
  - Response: `rd_data` holds 2 and `ram_a` holds 7 throughout; then 3, 4 follow.
  - No beat is lost or duplicated.
- Wrap-around:
  - Stimulus: addr 30 = 4'hA, 31 = 4'hB, 0 = 4'hC; read addr 30 with len 2.
  - Response without the macro: beats A, B, C.
  - Response with the macro: a single `cmd_err` pulse, no beats, and `ram_we` stays 0.

Source files
------------

// File: rtl/ram_port_master.sv
// Command-driven initiator for a single-port RAM with false synchronous read.
// Define RAM_MASTER_WRAP_ERR_EN to reject wrapping bursts with a cmd_err pulse.
module ram_port_master #(
  parameter int AW = 5,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_wdata,
  output logic          cmd_err,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last
);

  typedef enum logic [1:0] {IDLE, WRITE, RADDR, RDATA} state_t;

  localparam logic [AW-1:0] ONE = 1;

  state_t        state, state_next;
  logic [AW-1:0] addr_q, len_q, beat_q;
  logic [DW-1:0] data_q;
  logic          ready_q;
  logic          accept, reject, start, last, advance;

  assign accept  = cmd_valid & cmd_ready;
  assign start   = accept & ~reject;
  assign last    = (beat_q == len_q);
  assign advance = (state == RDATA) & rd_ready & ~last;

`ifdef RAM_MASTER_WRAP_ERR_EN
  logic [AW:0] end_addr;
  logic        err_q;

  // A carry out of the AW-bit sum means the burst would run past the top word.
  assign end_addr = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign reject   = accept & ~cmd_we & end_addr[AW];
  assign cmd_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= reject;
  end
`else
  assign reject  = 1'b0;
  assign cmd_err = 1'b0;
`endif

  // NOTE: combinational blocks assign every output a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = cmd_we ? WRITE : RADDR;
      WRITE:   state_next = IDLE;
      RADDR:   state_next = RDATA;
      RDATA:   if (rd_ready && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Presenting the next address while the beat is consumed keeps ram_do one
  // beat ahead; holding it under backpressure keeps ram_do stable.
  always_comb begin
    ram_a = addr_q;
    if (advance) ram_a = addr_q + ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
      if ((state == IDLE) && start) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        beat_q <= '0;
        if (cmd_we) data_q <= cmd_wdata;
      end else if (advance) begin
        addr_q <= addr_q + ONE;
        beat_q <= beat_q + ONE;
      end
    end
  end

  assign cmd_ready = ready_q;
  assign ram_we    = (state == WRITE);
  assign ram_di    = data_q;
  assign rd_valid  = (state == RDATA);
  assign rd_data   = ram_do;
  assign rd_last   = (state == RDATA) & last;

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master with a behavioural false-sync-read RAM.
// Covers reset, writes, single/burst reads, backpressure, wrap and mid-burst reset.
module tb_ram_port_master;

  localparam int AW = 5;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_we, cmd_err;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic [DW-1:0] cmd_wdata;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di, ram_do;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;

  int checks = 0;
  int failures = 0;

  ram_port_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .cmd_err(cmd_err),
    .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  // RAM model: address registered each edge, data read combinationally from it.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] a_reg = '0;
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
    a_reg <= ram_a;
  end
  assign ram_do = mem[a_reg];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   len;
    logic [DW-1:0]   wdata;
    logic [3:0][DW-1:0] exp;
  } vec_t;

  function automatic vec_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    vec_t v;
    v.we = 1'b1; v.addr = a; v.len = '0; v.wdata = d; v.exp = '0;
    return v;
  endfunction

  function automatic vec_t rd(input logic [AW-1:0] a, input logic [AW-1:0] l,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    vec_t v;
    v.we = 1'b0; v.addr = a; v.len = l; v.wdata = '0;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  // Drive a command from a point just after a negedge; returns #1 after the handshake edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [AW-1:0] l,
                      input logic [DW-1:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l; cmd_wdata = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    send(v.we, v.addr, v.len, v.wdata);
    @(negedge clk);
    if (v.we) begin
      check("wr_we", ram_we, 1);
      check("wr_a", ram_a, v.addr);
      check("wr_di", ram_di, v.wdata);
      @(negedge clk);
      check("wr_done_we", ram_we, 0);
      check("wr_done_ready", cmd_ready, 1);
    end else begin
      check("raddr_valid", rd_valid, 0);
      check("raddr_a", ram_a, v.addr);
      check("raddr_we", ram_we, 0);
      for (int i = 0; i <= int'(v.len); i++) begin
        @(negedge clk);
        check($sformatf("beat%0d_valid", i), rd_valid, 1);
        check($sformatf("beat%0d_data", i), rd_data, v.exp[i]);
        check($sformatf("beat%0d_last", i), rd_last, (i == int'(v.len)));
      end
      @(negedge clk);
      check("rd_end_valid", rd_valid, 0);
      check("rd_end_ready", cmd_ready, 1);
    end
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    vecs.push_back(wr(5'd3, 4'b1001));
    vecs.push_back(wr(5'd7, 4'b1100));
    vecs.push_back(rd(5'd3, 5'd0, 4'b1001, 4'h0, 4'h0, 4'h0));
    vecs.push_back(wr(5'd6, 4'd1));
    vecs.push_back(wr(5'd7, 4'd2));
    vecs.push_back(wr(5'd8, 4'd3));
    vecs.push_back(wr(5'd9, 4'd4));
    vecs.push_back(rd(5'd6, 5'd3, 4'd1, 4'd2, 4'd3, 4'd4));
    vecs.push_back(wr(5'd30, 4'hA));
    vecs.push_back(wr(5'd31, 4'hB));
    vecs.push_back(wr(5'd0, 4'hC));
    vecs.push_back(rd(5'd30, 5'd1, 4'hA, 4'hB, 4'h0, 4'h0));
    vecs.push_back(wr(5'd5, 4'hF));
    vecs.push_back(rd(5'd5, 5'd0, 4'hF, 4'h0, 4'h0, 4'h0));
    vecs.push_back(rd(5'd31, 5'd0, 4'hB, 4'h0, 4'h0, 4'h0));

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_wdata = '0; rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_ram_di", ram_di, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_cmd_err", cmd_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Backpressure: beat 2 stalled for 3 cycles.
    send(1'b0, 5'd6, 5'd3, 4'h0);
    @(negedge clk);
    check("bp_raddr_a", ram_a, 6);
    @(negedge clk);
    check("bp_beat0", rd_data, 1);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      rd_ready = 1'b0;
      #1;
      check($sformatf("bp_hold%0d_data", c), rd_data, 2);
      check($sformatf("bp_hold%0d_a", c), ram_a, 7);
      check($sformatf("bp_hold%0d_valid", c), rd_valid, 1);
      check($sformatf("bp_hold%0d_last", c), rd_last, 0);
      @(negedge clk);
    end
    rd_ready = 1'b1;
    #1;
    check("bp_release_data", rd_data, 2);
    check("bp_release_a", ram_a, 8);
    @(negedge clk);
    check("bp_beat2", rd_data, 3);
    check("bp_beat2_last", rd_last, 0);
    @(negedge clk);
    check("bp_beat3", rd_data, 4);
    check("bp_beat3_last", rd_last, 1);
    @(negedge clk);
    check("bp_end_valid", rd_valid, 0);

    // Wrap-around burst from address 30.
`ifdef RAM_MASTER_WRAP_ERR_EN
    send(1'b0, 5'd30, 5'd2, 4'h0);
    @(negedge clk);
    check("wrap_err_pulse", cmd_err, 1);
    check("wrap_err_ready", cmd_ready, 1);
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      if (rd_valid || ram_we) stale++;
      @(negedge clk);
      if (c == 0) check("wrap_err_clear", cmd_err, 0);
    end
    check("wrap_err_no_access", stale, 0);
`else
    run_vec(rd(5'd30, 5'd2, 4'hA, 4'hB, 4'hC, 4'h0));
    check("wrap_no_err", cmd_err, 0);
`endif

    // Reset in the 2nd RDATA cycle of a 4-word burst.
    send(1'b0, 5'd6, 5'd3, 4'h0);
    @(negedge clk);
    @(negedge clk);
    check("mid_beat0", rd_data, 1);
    @(negedge clk);
    check("mid_beat1_valid", rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_we", ram_we, 0);
    check("mid_rst_last", rd_last, 0);
    check("mid_rst_ready", cmd_ready, 0);
    check("mid_rst_a", ram_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rd_valid) stale++;
    end
    check("mid_no_stale", stale, 0);
    check("mid_ready_after", cmd_ready, 1);
    run_vec(rd(5'd3, 5'd0, 4'b1001, 4'h0, 4'h0, 4'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
